// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// hilo_muldiv_unit : multi-cycle MULT/MULTU/DIV unit owning the HI/LO registers
// Revision 1.0
// ============================================================================
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic             hilo_enable,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FIX    = 2'd2;
    localparam logic [3:0] CTL_DIV   = 4'd13;
    localparam logic [3:0] CTL_MULT  = 4'd14;
    localparam logic [3:0] CTL_MULTU = 4'd15;
    localparam int         CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

    logic [1:0]         state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc, low, opnd;
    logic               is_div, neg_lo, neg_hi;
    logic               fix_cycle, accept, op_valid;
    logic               is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_valid = (alu_ctl == CTL_DIV) || (alu_ctl == CTL_MULT) || (alu_ctl == CTL_MULTU);
    assign accept   = start && hilo_enable && (state == ST_IDLE) && op_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        fix_cycle = (state == ST_FIX);
    end

    always_comb begin
        is_signed = (alu_ctl != CTL_MULTU);
        a_neg     = is_signed && op_a[WIDTH-1];
        b_neg     = is_signed && op_b[WIDTH-1];
        a_mag     = a_neg ? (~op_a + WIDTH'(1)) : op_a;
        b_mag     = b_neg ? (~op_b + WIDTH'(1)) : op_b;
        // Multiply: add multiplicand when multiplier LSB set, then shift {acc,low} right.
        mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        // Divide: shift next dividend bit into the partial remainder and trial-subtract.
        div_shift = {acc, low[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        prod      = {acc, low};
        prod_fix  = neg_lo ? (~prod + (2*WIDTH)'(1)) : prod;
        quo_fix   = neg_lo ? (~low + WIDTH'(1)) : low;
        rem_fix   = neg_hi ? (~acc + WIDTH'(1)) : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            low    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= fix_cycle;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        acc    <= '0;
                        is_div <= (alu_ctl == CTL_DIV);
                        if (alu_ctl == CTL_DIV) begin
                            low    <= a_mag;
                            opnd   <= b_mag;
                            // A zero divisor must leave the all-ones quotient un-negated.
                            neg_lo <= (a_neg ^ b_neg) && (op_b != '0);
                            neg_hi <= a_neg;
                        end else begin
                            low    <= b_mag;
                            opnd   <= a_mag;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        if (!div_trial[WIDTH]) begin
                            acc <= div_trial[WIDTH-1:0];
                            low <= {low[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_shift[WIDTH-1:0];
                            low <= {low[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        low <= {mul_sum[0], low[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_hilo_muldiv_unit : directed self-checking bench for hilo_muldiv_unit
// Revision 1.0
// ============================================================================
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_ctl;
    logic         hilo_enable;
    logic [W-1:0] op_a, op_b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int compared   = 0;
    int mismatched = 0;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_ctl     (alu_ctl),
        .hilo_enable (hilo_enable),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the op is accepted at the following posedge.
    task automatic start_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        start       = 1'b1;
        hilo_enable = 1'b1;
        alu_ctl     = ctl;
        op_a        = a;
        op_b        = b;
        @(posedge clk);
        #1;
        start       = 1'b0;
        hilo_enable = 1'b0;
        alu_ctl     = 4'd0;
        op_a        = 32'hDEADBEEF;
        op_b        = 32'h0BADF00D;
    endtask

    // Checks busy through T+1..T+W+1, then the result in T+W+2; ends at that negedge.
    task automatic wait_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                               input int inject_k);
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            start       = 1'b0;
            hilo_enable = 1'b0;
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done_low"}, 32'(done), 32'd0);
            if (k == inject_k) begin
                start       = 1'b1;
                hilo_enable = 1'b1;
                alu_ctl     = 4'd15;
                op_a        = 32'h12345678;
                op_b        = 32'h00000009;
            end
        end
        @(negedge clk);
        start       = 1'b0;
        hilo_enable = 1'b0;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_low"}, 32'(busy), 32'd0);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        hilo_enable = 1'b0;
        alu_ctl     = 4'd0;
        op_a        = '0;
        op_b        = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_result("multu_max", 32'hFFFFFFFE, 32'h00000001, 0);
        @(negedge clk);
        chk("multu_max done_pulse_end", 32'(done), 32'd0);

        // Ignored: HI/LO enable low, then an out-of-set control code.
        start = 1'b1; hilo_enable = 1'b0; alu_ctl = 4'd14; op_a = 32'd5; op_b = 32'd5;
        repeat (2) @(negedge clk);
        chk("no_enable busy", 32'(busy), 32'd0);
        chk("no_enable hi", hi, 32'hFFFFFFFE);
        chk("no_enable lo", lo, 32'h00000001);
        hilo_enable = 1'b1; alu_ctl = 4'd7;
        repeat (2) @(negedge clk);
        chk("bad_code busy", 32'(busy), 32'd0);
        chk("bad_code done", 32'(done), 32'd0);
        chk("bad_code lo", lo, 32'h00000001);
        start = 1'b0; hilo_enable = 1'b0; alu_ctl = 4'd0;
        @(negedge clk);

        start_op(4'd14, 32'hFFFFFFFD, 32'd7);
        wait_result("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        @(negedge clk);
        start_op(4'd14, 32'h80000000, 32'h80000000);
        wait_result("mult_min", 32'h40000000, 32'h00000000, 0);
        @(negedge clk);
        start_op(4'd13, 32'hFFFFFFF9, 32'd2);
        wait_result("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        @(negedge clk);
        start_op(4'd13, 32'h80000000, 32'hFFFFFFFF);
        wait_result("div_wrap", 32'h00000000, 32'h80000000, 0);
        @(negedge clk);
        start_op(4'd13, 32'd100, 32'd0);
        wait_result("div_zero", 32'h00000064, 32'hFFFFFFFF, 0);

        // Back-to-back accept in the done cycle.
        start_op(4'd15, 32'h00010000, 32'h00010000);
        wait_result("b2b", 32'h00000001, 32'h00000000, 0);
        @(negedge clk);
        chk("b2b done_pulse_end", 32'(done), 32'd0);

        // A start pulse in RUN cycle 5 must not disturb the running MULT.
        start_op(4'd14, 32'd6, 32'd7);
        wait_result("busy_start", 32'h00000000, 32'h0000002A, 5);
        @(negedge clk);
        chk("busy_start no_requeue", 32'(busy), 32'd0);

        // Reset asserted in RUN cycle 10 aborts with no done pulse.
        start_op(4'd15, 32'hFFFFFFFF, 32'h00000002);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("abort busy", 32'(busy), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("abort busy_low", 32'(busy), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("abort no_done", 32'(done), 32'd0);
        end
        chk("abort idle", 32'(busy), 32'd0);
        chk("abort hi_held", hi, 32'd0);
        chk("abort lo_held", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide execution unit that consumes the ALU-control decode (4-bit control code plus HI/LO enable) and owns the architectural HI and LO registers. It sits beside the single-cycle ALU in the execute stage. Codes 13, 14 and 15 with the HI/LO enable set are routed here instead of to the ALU result path. It raises `busy` so the pipeline stalls until HI/LO are written.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  execute-stage instruction valid this cycle.
- `alu_ctl`  in  4  decoded control code: 14 = MULT (signed), 15 = MULTU, 13 = DIV (signed); all other codes are ignored.
- `hilo_enable`  in  1  decode marks the instruction as a HI/LO operation.
- `op_a`  in  WIDTH  rs value: multiplicand or dividend.
- `op_b`  in  WIDTH  rt value: multiplier or divisor.
- `busy`  out  1  operation in flight; pipeline must stall and hold its inputs.
- `done`  out  1  one-cycle pulse when the new HI/LO become visible.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- Accept condition: `start && hilo_enable && !busy && alu_ctl ∈ {13,14,15}`.
  - If `hilo_enable` is low, or the code is outside that set, the inputs are ignored and no state changes.
- FSM states: IDLE, RUN, FIX.
  - IDLE → RUN on accept. Latch the operand magnitudes (signed ops only), the result-sign flags and the op type. Clear the iteration counter.
  - RUN lasts exactly `WIDTH` cycles: one shift-add step per cycle (multiply) or one restoring-subtract step per cycle (divide). RUN → FIX when the counter reaches `WIDTH-1`.
  - FIX lasts one cycle. Apply the sign correction, write HI/LO, then go to IDLE and set `done` for the next cycle.
- `busy` = state ≠ IDLE, decoded from registered state.
- Multiply: 2·WIDTH-bit product; HI = upper half, LO = lower half.
  - MULT: operate on magnitudes; negate the product if the operand signs differ.
  - MULTU: raw unsigned.
- Divide (DIV): operate on magnitudes.
  - Quotient is negated if the signs differ. The remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps, no trap).
- Divide by zero: full latency is still spent. Result is LO = all ones and HI = `op_a` unchanged. No exception.
- HI/LO change only at the end of FIX. Between operations they hold their value indefinitely.
- `start` while busy is ignored with no queueing; upstream must hold its stall.

## Timing
- Reset values (asynchronous): state = IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter = 0.
- Accept sampled at edge E0 (end of cycle T).
  - `busy` = 1 in cycles T+1 … T+WIDTH+1.
  - RUN occupies T+1 … T+WIDTH; FIX occupies T+WIDTH+1.
- In cycle T+WIDTH+2: new `hi`/`lo` are visible, `done` = 1 and `busy` = 0.
  - Latency from accept to result is WIDTH+2 cycles (34 for WIDTH = 32).
- Back-to-back: a new accept is legal in the `done` cycle. The next op's `busy` rises the following cycle, so throughput is one op per WIDTH+2 cycles.
- `done` is low in every cycle except the single pulse cycle.
- Reset asserted mid-RUN or mid-FIX: abort immediately. HI/LO clear to 0 and no `done` pulse is produced. After deassertion the unit sits in IDLE.
- Operand inputs are don't-care after the accept edge; they are latched internally.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF accepted at T → at T+34: HI = 0xFFFFFFFE, LO = 0x00000001, `done` = 1 for one cycle, `busy` high for T+1…T+33.
- MULT -3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIV 100 / 0 → after 34 cycles, LO = 0xFFFFFFFF, HI = 0x00000064.
- Ignored inputs:
  - `start` with `alu_ctl` = 14 but `hilo_enable` = 0 → no busy, HI/LO unchanged.
  - `start` pulsed in RUN cycle 5 with different operands → ignored, and the original result is delivered.
  - New accept in the `done` cycle → `busy` reasserts the next cycle and the second result arrives 34 cycles later.
- Reset: `rst_n` low during RUN cycle 10 of a MULTU → `busy` = 0, `hi` = `lo` = 0 immediately, and no `done` pulse follows.
